// File: rtl/exec_unit_pkg.sv
// ============================================================================
//  exec_unit_pkg : shared constants, op-field encodings and FSM state type
//  Optional M-extension build macro: EXEC_UNIT_MUL_DIV_EN
//  Revision: 1.0
// ============================================================================
`default_nettype none

package exec_unit_pkg;

    localparam int c_XLEN_DEFAULT    = 32;
    localparam int c_ROB_SIZE_WIDTH  = 4;

    // op[5] M-ext, op[4] branch compare, op[3] alternate (sub/sra)
    localparam int c_OP_MEXT = 5;
    localparam int c_OP_BR   = 4;
    localparam int c_OP_ALT  = 3;

    localparam logic [2:0] c_F3_ADD  = 3'b000;
    localparam logic [2:0] c_F3_SLL  = 3'b001;
    localparam logic [2:0] c_F3_SLT  = 3'b010;
    localparam logic [2:0] c_F3_SLTU = 3'b011;
    localparam logic [2:0] c_F3_XOR  = 3'b100;
    localparam logic [2:0] c_F3_SR   = 3'b101;
    localparam logic [2:0] c_F3_OR   = 3'b110;
    localparam logic [2:0] c_F3_AND  = 3'b111;

    localparam logic [2:0] c_BR_EQ  = 3'b000;
    localparam logic [2:0] c_BR_NE  = 3'b001;
    localparam logic [2:0] c_BR_LT  = 3'b100;
    localparam logic [2:0] c_BR_GE  = 3'b101;
    localparam logic [2:0] c_BR_LTU = 3'b110;
    localparam logic [2:0] c_BR_GEU = 3'b111;

    localparam logic [1:0] c_M_MUL    = 2'b00;
    localparam logic [1:0] c_M_MULH   = 2'b01;
    localparam logic [1:0] c_M_MULHSU = 2'b10;
    localparam logic [1:0] c_M_MULHU  = 2'b11;

`ifdef EXEC_UNIT_MUL_DIV_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd3
    } state_t;
`endif

endpackage

`default_nettype wire

// File: rtl/exec_unit_if.sv
// ============================================================================
//  exec_unit_if : issue request and result-broadcast signals of exec_unit
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface exec_unit_if
    import exec_unit_pkg::*;
#(
    parameter int XLEN           = c_XLEN_DEFAULT,
    parameter int ROB_SIZE_WIDTH = c_ROB_SIZE_WIDTH
);
    logic                      in_valid;
    logic                      in_ready;
    logic [5:0]                op;
    logic [ROB_SIZE_WIDTH-1:0] rob_id_in;
    logic [XLEN-1:0]           v1;
    logic [XLEN-1:0]           v2;
    logic                      out_valid;
    logic                      out_grant;
    logic [ROB_SIZE_WIDTH-1:0] rob_id_out;
    logic [XLEN-1:0]           result;

    modport master (
        output in_valid, op, rob_id_in, v1, v2, out_grant,
        input  in_ready, out_valid, rob_id_out, result
    );

    modport slave (
        input  in_valid, op, rob_id_in, v1, v2, out_grant,
        output in_ready, out_valid, rob_id_out, result
    );
endinterface

`default_nettype wire

// File: rtl/exec_unit_div.sv
// ============================================================================
//  exec_div : radix-2 restoring divider, XLEN iterations, signed/unsigned,
//             RISC-V divide-by-zero and overflow results.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module exec_div
    import exec_unit_pkg::*;
#(
    parameter int XLEN = c_XLEN_DEFAULT
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            i_en,
    input  wire logic            i_abort,
    input  wire logic            i_start,
    input  wire logic            i_signed,
    input  wire logic            i_rem,
    input  wire logic [XLEN-1:0] i_dividend,
    input  wire logic [XLEN-1:0] i_divisor,
    output logic                 o_done,
    output logic [XLEN-1:0]      o_result
);
    localparam int c_CW = $clog2(XLEN + 1);

    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_dvsr;
    logic [c_CW-1:0] r_cnt;
    logic            r_busy;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_want_rem;
    logic            r_dvz;

    logic            w_a_neg;
    logic            w_b_neg;
    logic            w_b_zero;
    logic [XLEN-1:0] w_a_abs;
    logic [XLEN-1:0] w_b_abs;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;

    assign w_a_neg  = i_signed && i_dividend[XLEN-1];
    assign w_b_neg  = i_signed && i_divisor[XLEN-1];
    assign w_b_zero = (i_divisor == '0);
    assign w_a_abs  = w_a_neg ? -i_dividend : i_dividend;
    assign w_b_abs  = w_b_neg ? -i_divisor  : i_divisor;
    assign w_shift  = {r_rem, r_quo[XLEN-1]};
    assign w_diff   = w_shift - {1'b0, r_dvsr};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_quo      <= '0;
            r_rem      <= '0;
            r_dvsr     <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_want_rem <= 1'b0;
            r_dvz      <= 1'b0;
        end else if (i_en) begin
            if (i_abort) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else if (i_start) begin
                r_busy     <= 1'b1;
                r_cnt      <= '0;
                r_want_rem <= i_rem;
                r_dvsr     <= w_b_abs;
                r_dvz      <= w_b_zero;
                // Divide by zero: preload the architectural answer and skip the shifts
                if (w_b_zero) begin
                    r_quo   <= '1;
                    r_rem   <= i_dividend;
                    r_neg_q <= 1'b0;
                    r_neg_r <= 1'b0;
                end else begin
                    r_quo   <= w_a_abs;
                    r_rem   <= '0;
                    r_neg_q <= w_a_neg ^ w_b_neg;
                    r_neg_r <= w_a_neg;
                end
            end else if (r_busy) begin
                if (r_cnt == c_CW'(XLEN)) begin
                    r_busy <= 1'b0;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CW'(1);
                    if (!r_dvz) begin
                        if (!w_diff[XLEN]) begin
                            r_rem <= w_diff[XLEN-1:0];
                            r_quo <= {r_quo[XLEN-2:0], 1'b1};
                        end else begin
                            r_rem <= w_shift[XLEN-1:0];
                            r_quo <= {r_quo[XLEN-2:0], 1'b0};
                        end
                    end
                end
            end
        end
    end

    assign o_done   = r_busy && (r_cnt == c_CW'(XLEN));
    assign o_result = r_want_rem ? (r_neg_r ? -r_rem : r_rem)
                                 : (r_neg_q ? -r_quo : r_quo);

endmodule

`default_nettype wire

// File: rtl/exec_unit.sv
// ============================================================================
//  exec_unit : single-issue ALU / branch-compare / optional M-ext unit with a
//              held result awaiting broadcast grant. Macro: EXEC_UNIT_MUL_DIV_EN
//  Revision: 1.0
// ============================================================================
`default_nettype none

module exec_unit
    import exec_unit_pkg::*;
#(
    parameter int XLEN           = c_XLEN_DEFAULT,
    parameter int ROB_SIZE_WIDTH = c_ROB_SIZE_WIDTH
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    input  wire logic  rdy,
    input  wire logic  flush,
    exec_unit_if.slave bus
);
    localparam int c_SHW = $clog2(XLEN);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_out_valid;
    logic [XLEN-1:0]           r_result;
    logic [ROB_SIZE_WIDTH-1:0] r_rob_id;

    logic                      w_in_ready;
    logic                      w_accept;
    logic                      w_grant;
    logic                      w_set_out;
    logic                      w_clr_out;
    logic [XLEN-1:0]           w_res_nxt;
    logic [ROB_SIZE_WIDTH-1:0] w_tag_nxt;
    logic [XLEN-1:0]           w_alu_res;
    logic [c_SHW-1:0]          w_shamt;
    logic [2:0]                w_f3;

    assign w_f3       = bus.op[2:0];
    assign w_shamt    = bus.v2[c_SHW-1:0];
    assign w_in_ready = rdy && (r_state == ST_IDLE) && (!r_out_valid || bus.out_grant);
    assign w_accept   = bus.in_valid && w_in_ready && !flush;
    assign w_grant    = rdy && !flush && r_out_valid && bus.out_grant;
    assign w_clr_out  = rdy && (flush || w_grant);

    always_comb begin
        w_alu_res = '0;
        if (bus.op[c_OP_MEXT]) begin
            w_alu_res = '0;
        end else if (bus.op[c_OP_BR]) begin
            case (w_f3)
                c_BR_EQ:  w_alu_res = XLEN'(bus.v1 == bus.v2);
                c_BR_NE:  w_alu_res = XLEN'(bus.v1 != bus.v2);
                c_BR_LT:  w_alu_res = XLEN'($signed(bus.v1) <  $signed(bus.v2));
                c_BR_GE:  w_alu_res = XLEN'($signed(bus.v1) >= $signed(bus.v2));
                c_BR_LTU: w_alu_res = XLEN'(bus.v1 <  bus.v2);
                c_BR_GEU: w_alu_res = XLEN'(bus.v1 >= bus.v2);
                default:  w_alu_res = '0;
            endcase
        end else begin
            case (w_f3)
                c_F3_ADD:  w_alu_res = bus.op[c_OP_ALT] ? (bus.v1 - bus.v2) : (bus.v1 + bus.v2);
                c_F3_SLL:  w_alu_res = bus.v1 << w_shamt;
                c_F3_SLT:  w_alu_res = XLEN'($signed(bus.v1) < $signed(bus.v2));
                c_F3_SLTU: w_alu_res = XLEN'(bus.v1 < bus.v2);
                c_F3_XOR:  w_alu_res = bus.v1 ^ bus.v2;
                c_F3_SR:   w_alu_res = bus.op[c_OP_ALT] ? XLEN'($signed(bus.v1) >>> w_shamt)
                                                        : (bus.v1 >> w_shamt);
                c_F3_OR:   w_alu_res = bus.v1 | bus.v2;
                default:   w_alu_res = bus.v1 & bus.v2;
            endcase
        end
    end

`ifdef EXEC_UNIT_MUL_DIV_EN
    logic [XLEN-1:0]           r_v1;
    logic [XLEN-1:0]           r_v2;
    logic [1:0]                r_mop;
    logic [ROB_SIZE_WIDTH-1:0] r_tag;
    logic                      w_a_sgn;
    logic                      w_b_sgn;
    logic signed [2*XLEN-1:0]  w_ma;
    logic signed [2*XLEN-1:0]  w_mb;
    logic signed [2*XLEN-1:0]  w_prod;
    logic [XLEN-1:0]           w_mul_res;
    logic                      w_div_start;
    logic                      w_div_done;
    logic [XLEN-1:0]           w_div_res;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1  <= '0;
            r_v2  <= '0;
            r_mop <= '0;
            r_tag <= '0;
        end else if (w_accept) begin
            r_v1  <= bus.v1;
            r_v2  <= bus.v2;
            r_mop <= bus.op[1:0];
            r_tag <= bus.rob_id_in;
        end
    end

    // Sign-extend per operand signedness; the low 2*XLEN bits of the product are exact
    assign w_a_sgn   = (r_mop != c_M_MULHU) && r_v1[XLEN-1];
    assign w_b_sgn   = ((r_mop == c_M_MUL) || (r_mop == c_M_MULH)) && r_v2[XLEN-1];
    assign w_ma      = {{XLEN{w_a_sgn}}, r_v1};
    assign w_mb      = {{XLEN{w_b_sgn}}, r_v2};
    assign w_prod    = w_ma * w_mb;
    assign w_mul_res = (r_mop == c_M_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    exec_div #(
        .XLEN (XLEN)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (rdy),
        .i_abort    (flush),
        .i_start    (w_div_start),
        .i_signed   (!bus.op[0]),
        .i_rem      (bus.op[1]),
        .i_dividend (bus.v1),
        .i_divisor  (bus.v2),
        .o_done     (w_div_done),
        .o_result   (w_div_res)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_set_out   = 1'b0;
        w_res_nxt   = w_alu_res;
        w_tag_nxt   = bus.rob_id_in;
`ifdef EXEC_UNIT_MUL_DIV_EN
        w_div_start = 1'b0;
`endif
        if (rdy && !flush) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_set_out = 1'b1;
`ifdef EXEC_UNIT_MUL_DIV_EN
                        if (bus.op[c_OP_MEXT]) begin
                            w_set_out = 1'b0;
                            if (bus.op[2]) begin
                                w_state_nxt = ST_DIV;
                                w_div_start = 1'b1;
                            end else begin
                                w_state_nxt = ST_MUL;
                            end
                        end
`endif
                    end
                end
`ifdef EXEC_UNIT_MUL_DIV_EN
                ST_MUL: begin
                    w_set_out   = 1'b1;
                    w_res_nxt   = w_mul_res;
                    w_tag_nxt   = r_tag;
                    w_state_nxt = ST_HOLD;
                end
                ST_DIV: begin
                    if (w_div_done) begin
                        w_set_out   = 1'b1;
                        w_res_nxt   = w_div_res;
                        w_tag_nxt   = r_tag;
                        w_state_nxt = ST_HOLD;
                    end
                end
`endif
                ST_HOLD: begin
                    if (w_grant) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end else if (rdy) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // A fresh result outranks clearing the one granted in the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_rob_id    <= '0;
        end else if (w_set_out) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res_nxt;
            r_rob_id    <= w_tag_nxt;
        end else if (w_clr_out) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.result     = r_result;
    assign bus.rob_id_out = r_rob_id;

endmodule

`default_nettype wire

// File: tb/tb_exec_unit.sv
// ============================================================================
//  tb_exec_unit : directed and randomized self-checking bench for exec_unit
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_exec_unit;
    import exec_unit_pkg::*;

    localparam int XLEN = 32;
    localparam int RW   = 4;
`ifdef EXEC_UNIT_MUL_DIV_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rdy   = 1'b1;
    logic flush = 1'b0;

    exec_unit_if #(.XLEN(XLEN), .ROB_SIZE_WIDTH(RW)) bus ();

    exec_unit #(.XLEN(XLEN), .ROB_SIZE_WIDTH(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (rdy),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference behaviour straight from the instruction semantics
    function automatic logic [31:0] model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        int                sa;
        int                sb;
        int unsigned       sh;
        longint            p;
        longint unsigned   pu;
        sa = a;
        sb = b;
        sh = b[4:0];
        if (op[5]) begin
            if (!MEXT) return 32'h0;
            case (op[2:0])
                3'd0: return a * b;
                3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
                3'd2: begin p = longint'(sa) * longint'({32'h0, b}); return p[63:32]; end
                3'd3: begin pu = {32'h0, a} * {32'h0, b}; return pu[63:32]; end
                3'd4: begin
                    if (b == 0) return 32'hFFFF_FFFF;
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                    return sa / sb;
                end
                3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
                3'd6: begin
                    if (b == 0) return a;
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                    return sa % sb;
                end
                default: return (b == 0) ? a : a % b;
            endcase
        end
        if (op[4]) begin
            case (op[2:0])
                3'd0:    return 32'(a == b);
                3'd1:    return 32'(a != b);
                3'd4:    return 32'(sa < sb);
                3'd5:    return 32'(sa >= sb);
                3'd6:    return 32'(a < b);
                3'd7:    return 32'(a >= b);
                default: return 32'h0;
            endcase
        end
        case (op[2:0])
            3'd0:    return op[3] ? a - b : a + b;
            3'd1:    return a << sh;
            3'd2:    return 32'(sa < sb);
            3'd3:    return 32'(a < b);
            3'd4:    return a ^ b;
            3'd5:    return op[3] ? 32'(sa >>> sh) : a >> sh;
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic int latency(input logic [5:0] op);
        if (op[5] && MEXT) return op[2] ? XLEN + 2 : 2;
        return 1;
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // Called on a falling edge with the unit idle and no result pending
    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag, input int hold, input string name);
        logic [31:0] exp;
        int          k;
        exp = model(op, a, b);
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.v1        = a;
        bus.v2        = b;
        bus.rob_id_in = tag;
        bus.out_grant = 1'b0;
        #1 check({name, " in_ready"}, bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        k = 1;
        while (!bus.out_valid && k < 60) begin
            @(negedge clk);
            k++;
        end
        check({name, " latency"}, k, latency(op));
        check({name, " result"}, bus.result, exp);
        check({name, " tag"}, bus.rob_id_out, tag);
        repeat (hold) @(negedge clk);
        if (hold > 0) check({name, " held"}, {bus.out_valid, bus.rob_id_out, bus.result}, {1'b1, tag, exp});
        bus.out_grant = 1'b1;
        @(negedge clk);
        bus.out_grant = 1'b0;
        check({name, " consumed"}, bus.out_valid, 0);
    endtask

`ifdef EXEC_UNIT_MUL_DIV_EN
    task automatic div_abort(input bit use_reset, input string name);
        bit seen;
        bus.in_valid  = 1'b1;
        bus.op        = 6'b100100;
        bus.v1        = 32'd100;
        bus.v2        = 32'd7;
        bus.rob_id_in = 4'd4;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        if (use_reset) rst_n = 1'b0;
        else           flush = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        flush = 1'b0;
        check({name, " in_ready"}, bus.in_ready, 1);
        check({name, " out_valid"}, bus.out_valid, 0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= bus.out_valid;
        end
        check({name, " no result"}, seen, 0);
    endtask
`endif

    initial begin
        logic [31:0] exp1;
        logic [5:0]  rop;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.v1        = '0;
        bus.v2        = '0;
        bus.rob_id_in = '0;
        bus.out_grant = 1'b0;

        repeat (3) @(negedge clk);
        check("reset out_valid", bus.out_valid, 0);
        check("reset result", bus.result, 0);
        check("reset tag", bus.rob_id_out, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(6'b000000, 32'd5, 32'hFFFF_FFFD, 4'd2, 0, "add");
        run_op(6'b001101, 32'h8000_0000, 32'd4, 4'd5, 0, "sra");
        run_op(6'b010110, 32'd1, 32'hFFFF_FFFF, 4'd6, 0, "bltu");
        run_op(6'b001000, 32'd3, 32'd10, 4'd7, 1, "sub");
        run_op(6'b010010, 32'd3, 32'd3, 4'd8, 0, "br f3=010");

`ifdef EXEC_UNIT_MUL_DIV_EN
        run_op(6'b100100, 32'hFFFF_FFF9, 32'd2, 4'd1, 0, "div");
        run_op(6'b100110, 32'hFFFF_FFF9, 32'd2, 4'd2, 0, "rem");
        run_op(6'b100101, 32'd9, 32'd0, 4'd3, 0, "divu by 0");
        run_op(6'b100100, 32'h8000_0000, 32'hFFFF_FFFF, 4'd4, 0, "div ovf");
        run_op(6'b100110, 32'h8000_0000, 32'hFFFF_FFFF, 4'd5, 0, "rem ovf");
        run_op(6'b100001, 32'h8000_0000, 32'd2, 4'd6, 2, "mulh");
        run_op(6'b100011, 32'h8000_0000, 32'd2, 4'd7, 0, "mulhu");
        div_abort(1'b0, "div flush");
        div_abort(1'b1, "div reset");
        run_op(6'b100111, 32'd100, 32'd7, 4'd9, 0, "remu after abort");
`else
        run_op(6'b100000, 32'd7, 32'd9, 4'd1, 0, "mext disabled");
`endif

        // Held result survives no-grant cycles, rdy low and a grant while rdy is low
        bus.in_valid  = 1'b1;
        bus.op        = 6'b000100;
        bus.v1        = 32'h0000_F0F0;
        bus.v2        = 32'h0000_0FF0;
        bus.rob_id_in = 4'd9;
        exp1 = model(6'b000100, 32'h0000_F0F0, 32'h0000_0FF0);
        @(negedge clk);
        bus.op = 6'b000000;
        bus.v1 = 32'd100;
        bus.v2 = 32'd23;
        bus.rob_id_in = 4'd10;
        for (int i = 0; i < 5; i++) begin
            rdy           = (i == 1 || i == 2) ? 1'b0 : 1'b1;
            bus.out_grant = (i == 2);
            #1 check("hold in_ready", bus.in_ready, 0);
            @(negedge clk);
            check("hold output", {bus.out_valid, bus.rob_id_out, bus.result}, {1'b1, 4'd9, exp1});
        end
        rdy           = 1'b1;
        bus.out_grant = 1'b1;
        #1 check("b2b in_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_grant = 1'b0;
        check("b2b result", {bus.out_valid, bus.rob_id_out, bus.result}, {1'b1, 4'd10, 32'd123});

        // Reset outranks flush and rdy low
        rst_n = 1'b0;
        flush = 1'b1;
        rdy   = 1'b0;
        @(negedge clk);
        check("rst prio output", {bus.out_valid, bus.rob_id_out, bus.result}, 37'h0);
        rst_n = 1'b1;
        flush = 1'b0;
        rdy   = 1'b1;
        #1 check("rst prio in_ready", bus.in_ready, 1);
        @(negedge clk);

        // Flush drops a held result and beats a simultaneous accept and grant
        bus.in_valid  = 1'b1;
        bus.op        = 6'b000111;
        bus.v1        = 32'hFF;
        bus.v2        = 32'h0F;
        bus.rob_id_in = 4'd3;
        @(negedge clk);
        check("pre-flush valid", bus.out_valid, 1);
        bus.op        = 6'b000110;
        bus.out_grant = 1'b1;
        flush         = 1'b1;
        @(negedge clk);
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_grant = 1'b0;
        check("flush out_valid", bus.out_valid, 0);
        #1 check("flush in_ready", bus.in_ready, 1);
        @(negedge clk);
        check("flush no accept", bus.out_valid, 0);

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 2))
                0:       rop = {2'b00, 4'($urandom)};
                1:       rop = {2'b01, 4'($urandom)};
                default: rop = {1'b1, 5'($urandom)};
            endcase
            run_op(rop, pick_val(), pick_val(), 4'($urandom), $urandom_range(0, 2),
                   $sformatf("rnd op=%b", rop));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
